// File: rtl/keccak_obi_ctrl.sv
// OBI slave front-end for the Keccak-f[1600] core: state buffers, start/done sequencing, done IRQ.
// Optional KECCAK_OBI_PERF_EN adds a saturating busy-cycle counter at word 52.

package keccak_obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module keccak_obi_ctrl
  import keccak_obi_pkg::*;
#(
  parameter int unsigned NWORDS   = 50,
  parameter int unsigned ADDR_LSB = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  obi_req_t         slave_req_i,
  output obi_resp_t        slave_resp_o,
  output logic             keccak_start_o,
  output logic [1599:0]    keccak_din_o,
  input  logic [1599:0]    keccak_dout_i,
  input  logic             keccak_done_i,
  output logic             intr_o
);

  localparam int unsigned WordSelW = $clog2(NWORDS);

  typedef enum logic [1:0] {StIdle, StStart, StBusy} state_e;

  state_e state_q, state_d;

  logic [NWORDS-1:0][31:0] din_q;
  logic [NWORDS-1:0][31:0] dout_q;
  logic [31:0]             rdata_q, rdata_d;
  logic                    rvalid_q;
  logic                    done_q, done_d;
  logic                    busy;

  logic [6:0]          word_idx;
  logic [WordSelW-1:0] word_sel;
  logic                wr, rd, is_data, ctrl_hit, status_hit;
  logic                start_req, w1c, go_start, done_evt;
  logic                unused_addr;

  assign word_idx    = slave_req_i.addr[ADDR_LSB+6:ADDR_LSB];
  assign word_sel    = word_idx[WordSelW-1:0];
  assign unused_addr = ^{slave_req_i.addr[31:ADDR_LSB+7], slave_req_i.addr[ADDR_LSB-1:0]};

  assign wr         = slave_req_i.req & slave_req_i.we;
  assign rd         = slave_req_i.req & ~slave_req_i.we;
  assign is_data    = word_idx < 7'(NWORDS);
  assign ctrl_hit   = word_idx == 7'(NWORDS);
  assign status_hit = word_idx == 7'(NWORDS + 1);

  assign start_req = wr & ctrl_hit & slave_req_i.be[0] & slave_req_i.wdata[0];
  assign w1c       = wr & status_hit & slave_req_i.be[0] & slave_req_i.wdata[0];
  assign go_start  = (state_q == StIdle) & start_req;
  assign done_evt  = (state_q == StBusy) & keccak_done_i;

  always_comb begin
    state_d        = state_q;
    keccak_start_o = 1'b0;
    busy           = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_req) state_d = StStart;
      end
      StStart: begin
        keccak_start_o = 1'b1;
        busy           = 1'b1;
        state_d        = StBusy;
      end
      StBusy: begin
        busy = 1'b1;
        if (keccak_done_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef KECCAK_OBI_PERF_EN
  logic [31:0] cycles_q;

  // Counts every BUSY cycle including the done cycle, then holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else if (go_start) begin
      cycles_q <= '0;
    end else if ((state_q == StBusy) && (cycles_q != '1)) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      if (is_data) begin
        rdata_d = dout_q[word_sel];
      end else if (status_hit) begin
        rdata_d = {30'b0, busy, done_q};
`ifdef KECCAK_OBI_PERF_EN
      end else if (word_idx == 7'(NWORDS + 2)) begin
        rdata_d = cycles_q;
`endif
      end
    end
  end

  // A done capture beats a same-cycle W1C.
  always_comb begin
    done_d = done_q;
    if (done_evt) begin
      done_d = 1'b1;
    end else if (go_start || w1c) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      din_q    <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rvalid_q <= slave_req_i.req;
      done_q   <= done_d;
      // Input state is frozen while the core runs.
      if (wr && is_data && (state_q == StIdle)) begin
        for (int b = 0; b < 4; b++) begin
          if (slave_req_i.be[b]) din_q[word_sel][8*b +: 8] <= slave_req_i.wdata[8*b +: 8];
        end
      end
      if (done_evt) dout_q <= keccak_dout_i;
    end
  end

  assign keccak_din_o        = din_q;
  assign intr_o              = done_q;
  assign slave_resp_o.gnt    = slave_req_i.req;
  assign slave_resp_o.rvalid = rvalid_q;
  assign slave_resp_o.rdata  = rdata_q;

endmodule
